// File: rtl/ctrl_unit_seq_if.sv
// ctrl_unit_seq_if: command handshake between the command sequencer (master)
// and ctrl_unit_seq (slave). A command transfers when cmd_valid and cmd_ready
// are both high at a rising clock edge.
interface ctrl_unit_seq_if #(
  parameter int SEL_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [SEL_W-1:0] cmd_sel;
  logic [1:0]       cmd_op;

  modport master (
    output cmd_valid,
    output cmd_sel,
    output cmd_op,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_sel,
    input  cmd_op,
    output cmd_ready
  );
endinterface

// File: rtl/ctrl_unit_seq.sv
// ctrl_unit_seq: sequential control unit. Accepts one command at a time over a
// valid/ready handshake, strobes the addressed channel(s) for one cycle and
// tracks their acknowledges against a timeout counter. Reports done, err and a
// sticky timeout flag.
// Optional build macro: CTRL_UNIT_SEQ_RETRY_EN -- on the first timeout the
// still-unacknowledged channels are strobed once more before the flag is set.
module ctrl_unit_seq #(
  parameter int NUM_CH  = 4,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ctrl_unit_seq_if.slave    cmd,
  input  logic              inhibit,
  output logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] ch_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam int               SEL_LIM_W = SEL_W + 1;
  localparam logic [SEL_W:0]   SEL_LIMIT = SEL_LIM_W'(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] target_q, target_d;
  logic [NUM_CH-1:0] ack_q, ack_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
  logic [NUM_CH-1:0] ack_now;
  logic [NUM_CH-1:0] strobe_mask;
  logic              all_acked;
  logic              sel_oob;
`ifdef CTRL_UNIT_SEQ_RETRY_EN
  logic              retry_q, retry_d;
`endif

  // A retry strobe only re-drives channels that have not acknowledged yet;
  // on the first strobe the ack mask is empty so this is the full target.
`ifdef CTRL_UNIT_SEQ_RETRY_EN
  assign strobe_mask = target_q & ~ack_q;
`else
  assign strobe_mask = target_q;
`endif

  assign sel_oob   = {1'b0, cmd.cmd_sel} >= SEL_LIMIT;
  assign ack_now   = ack_q | (ch_ack & target_q);
  assign all_acked = (ack_now == target_q);

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE) && !timeout_q;
  assign err           = (state_q == S_ERR);
  assign timeout       = timeout_q;

  // Next-state, strobe and bookkeeping decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    target_d  = target_q;
    ack_d     = ack_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    ch_en     = '0;
`ifdef CTRL_UNIT_SEQ_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          timeout_d = 1'b0;
          ack_d     = '0;
          cnt_d     = '0;
`ifdef CTRL_UNIT_SEQ_RETRY_EN
          retry_d   = 1'b0;
`endif
          case (cmd.cmd_op)
            2'b00: state_d = S_DONE;
            2'b01: begin
              if (sel_oob) begin
                state_d = S_ERR;
              end else begin
                target_d = {{(NUM_CH-1){1'b0}}, 1'b1} << cmd.cmd_sel;
                state_d  = S_ISSUE;
              end
            end
            2'b10: begin
              target_d = '1;
              state_d  = S_ISSUE;
            end
            default: state_d = S_ERR;  // op 11 is reserved
          endcase
        end
      end
      S_ISSUE: begin
        if (!inhibit) begin
          ch_en   = strobe_mask;
          ack_d   = ack_now;
          cnt_d   = '0;
          state_d = all_acked ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        ack_d = ack_now;
        if (all_acked) begin
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
`ifdef CTRL_UNIT_SEQ_RETRY_EN
          if (!retry_q) begin
            retry_d = 1'b1;
            cnt_d   = '0;
            state_d = S_ISSUE;
          end else begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end
`else
          timeout_d = 1'b1;
          state_d   = S_DONE;
`endif
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and bookkeeping registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q   <= S_IDLE;
      target_q  <= '0;
      ack_q     <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`ifdef CTRL_UNIT_SEQ_RETRY_EN
      retry_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      ack_q     <= ack_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`ifdef CTRL_UNIT_SEQ_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

endmodule

// File: tb/tb_ctrl_unit_seq.sv
// tb_ctrl_unit_seq: directed bench for ctrl_unit_seq (NUM_CH=4, TIMEOUT=3).
// Each command is described by op/sel/inhibit window and a per-cycle ack plan;
// a timeline model derives every output for every cycle of the command from
// the completion/timeout rules, and one compare process checks the DUT on the
// falling edge of each of those cycles.
module tb_ctrl_unit_seq;

  localparam int NCH  = 4;
  localparam int SELW = 4;
  localparam int TO   = 3;
  localparam int CW   = 4;
`ifdef CTRL_UNIT_SEQ_RETRY_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           inhibit;
  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] ch_ack;
  logic           busy;
  logic           done;
  logic           err;
  logic           timeout;

  ctrl_unit_seq_if #(.SEL_W(SELW)) cmd_if ();

  ctrl_unit_seq #(
    .NUM_CH (NCH),
    .SEL_W  (SELW),
    .TIMEOUT(TO),
    .CNT_W  (CW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmd    (cmd_if),
    .inhibit(inhibit),
    .ch_en  (ch_en),
    .ch_ack (ch_ack),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_err = 0;
  string scen  = "reset";
  int    cur_r = 0;
  bit    chk_on = 1'b0;

  // Per-cycle expectations for the command being run (index = cycles after T).
  logic [NCH-1:0] ack_plan [64];
  logic [NCH-1:0] e_en     [64];
  logic           e_done   [64];
  logic           e_err    [64];
  logic           e_busy   [64];
  logic           e_rdy    [64];
  logic           e_to     [64];
  int             last_r;
  int             pin_done_r;
  logic           to_prev = 1'b0;

  logic [NCH-1:0] x_en;
  logic           x_done, x_err, x_busy, x_rdy, x_to;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s r=%0d: got %0h, expected %0h", scen, name, cur_r, act, exp);
    end
  endtask

  // Single compare process: DUT outputs against the timeline model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("cmd_ready", 32'(cmd_if.cmd_ready), 32'(x_rdy));
      check("ch_en",     32'(ch_en),            32'(x_en));
      check("busy",      32'(busy),             32'(x_busy));
      check("done",      32'(done),             32'(x_done));
      check("err",       32'(err),              32'(x_err));
      check("timeout",   32'(timeout),          32'(x_to));
    end
  end

  task automatic clr_acks();
    for (int r = 0; r < 64; r++) ack_plan[r] = '0;
  endtask

  // Timeline model: a strobe opens a window of TIMEOUT further cycles; the
  // command completes the cycle after target acks (counted from the strobe
  // cycle) cover the target; an expired window re-strobes the missing
  // channels if a retry is left, otherwise raises the sticky timeout flag.
  task automatic plan(input logic [1:0] op, input int sel, input int inh_until);
    logic [NCH-1:0] tgt, cum;
    int  issue_r, dl, dc;
    bit  ok, timed;
    for (int r = 0; r < 64; r++) begin
      e_en[r] = '0; e_done[r] = 1'b0; e_err[r] = 1'b0;
      e_busy[r] = 1'b1; e_rdy[r] = 1'b0; e_to[r] = 1'b0;
    end
    ok = 1'b0; timed = 1'b0; pin_done_r = -1; dc = 1;
    if (op == 2'b11 || (op == 2'b01 && sel >= NCH)) begin
      e_err[1] = 1'b1;
    end else if (op == 2'b00) begin
      e_done[1] = 1'b1;
    end else begin
      tgt     = (op == 2'b01) ? NCH'(1 << sel) : '1;
      issue_r = (inh_until + 1 > 1) ? inh_until + 1 : 1;
      cum     = '0;
      for (int pass = 0; pass < NPASS && !ok; pass++) begin
        e_en[issue_r] = tgt & ~cum;
        dl = issue_r + TO;
        for (int r = issue_r; r <= dl && !ok; r++) begin
          cum |= ack_plan[r] & tgt;
          if (cum == tgt) begin
            ok = 1'b1;
            dc = r + 1;
          end
        end
        if (!ok) issue_r = dl + 1;
      end
      if (ok) begin
        e_done[dc] = 1'b1;
        pin_done_r = dc;
      end else begin
        timed = 1'b1;
        dc    = issue_r;
      end
    end
    last_r = dc + 1;
    e_busy[0] = 1'b0; e_rdy[0] = 1'b1; e_to[0] = to_prev;
    e_busy[last_r] = 1'b0; e_rdy[last_r] = 1'b1;
    for (int r = 1; r <= last_r; r++) e_to[r] = timed && (r >= dc);
    to_prev = timed;
  endtask

  // Drive one command from cycle T (r=0) until the block is idle again.
  // With noisy set, cmd_valid stays high with a reserved op while busy.
  task automatic run(input string name, input logic [1:0] op, input int sel,
                     input int inh_until, input bit noisy);
    scen = name;
    plan(op, sel, inh_until);
    for (int r = 0; r <= last_r; r++) begin
      cur_r              = r;
      cmd_if.cmd_valid   = (r == 0) || (noisy && r < last_r);
      cmd_if.cmd_op      = (r == 0) ? op : 2'b11;
      cmd_if.cmd_sel     = (r == 0) ? SELW'(sel) : 4'd7;
      inhibit            = (r <= inh_until);
      ch_ack             = ack_plan[r];
      x_en = e_en[r]; x_done = e_done[r]; x_err = e_err[r];
      x_busy = e_busy[r]; x_rdy = e_rdy[r]; x_to = e_to[r];
      chk_on = 1'b1;
      @(posedge clk); #1;
    end
    chk_on = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    ch_ack = '0;
    inhibit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; inhibit = 1'b0; ch_ack = '0;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 2'b00; cmd_if.cmd_sel = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready",   32'(cmd_if.cmd_ready), 32'd1);
    check("rst_ch_en",   32'(ch_en),            32'd0);
    check("rst_busy",    32'(busy),             32'd0);
    check("rst_done",    32'(done),             32'd0);
    check("rst_err",     32'(err),              32'd0);
    check("rst_timeout", 32'(timeout),          32'd0);
    @(posedge clk); #1;

    // Unicast sel=2; non-target acks in the strobe cycle, target ack at T+2.
    clr_acks(); ack_plan[1] = 4'b1011; ack_plan[2] = 4'b0100;
    run("unicast", 2'b01, 2, -1, 1'b0);
    check("pin_uni_done_r", 32'(pin_done_r), 32'd3);
    check("pin_uni_last_r", 32'(last_r),     32'd4);

    // Broadcast with acks spread over three cycles.
    clr_acks(); ack_plan[2] = 4'b0001; ack_plan[3] = 4'b1010; ack_plan[4] = 4'b0100;
    run("broadcast", 2'b10, 0, -1, 1'b0);
    check("pin_bc_done_r", 32'(pin_done_r), 32'd5);

    // Inhibit T..T+3; an ack during the inhibited cycles must not count.
    clr_acks(); ack_plan[2] = 4'b0001; ack_plan[5] = 4'b0001;
    run("inhibit", 2'b01, 0, 3, 1'b0);
    check("pin_inh_strobe", 32'(e_en[4]), 32'd1);

    // Timeout on sel=1 with only non-target acks.
    clr_acks(); ack_plan[2] = 4'b1101;
    run("timeout", 2'b01, 1, -1, 1'b0);
    check("pin_to_last_r", 32'(last_r), (NPASS == 2) ? 32'd10 : 32'd6);

    // Next accept (NOP) clears the sticky flag.
    clr_acks();
    run("nop_clear", 2'b00, 0, -1, 1'b0);

    // Illegal commands, with cmd_valid held high while busy.
    clr_acks();
    run("op11", 2'b11, 0, -1, 1'b1);
    run("sel5", 2'b01, 5, -1, 1'b0);
    run("sel4", 2'b01, 4, -1, 1'b0);

    // Minimum latency: ack in the strobe cycle, noisy cmd_valid while busy.
    clr_acks(); ack_plan[1] = 4'b1000;
    run("min_lat", 2'b01, 3, -1, 1'b1);
    check("pin_min_done_r", 32'(pin_done_r), 32'd2);

    // Partial broadcast ack: retry re-strobes only the missing channels.
    clr_acks(); ack_plan[2] = 4'b0011; ack_plan[6] = 4'b1100;
    run("bc_partial", 2'b10, 0, -1, 1'b0);

    // Reset mid-WAIT of a unicast sel=2.
    scen = "rst_mid_wait"; cur_r = 0;
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_op = 2'b01; cmd_if.cmd_sel = 4'd2;
    @(posedge clk); #1;
    cmd_if.cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ch_en",   32'(ch_en),            32'd0);
    check("post_rst_busy",    32'(busy),             32'd0);
    check("post_rst_ready",   32'(cmd_if.cmd_ready), 32'd1);
    check("post_rst_timeout", 32'(timeout),          32'd0);
    to_prev = 1'b0;
    @(posedge clk); #1;

    // Fresh unicast after reset: stale ack state must be gone.
    clr_acks(); ack_plan[3] = 4'b0100;
    run("after_rst", 2'b01, 2, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
